ring_node_router: RTL and testbench
===================================

# ring_node_router

Per-node router for the force-writeback ring network. It sits directly downstream of each cell's destination-ID mapping stage. It buffers the mapped writeback packets in an injection FIFO and merges them onto a unidirectional slotted ring, one register per hop. It ejects the force payload of any ring packet addressed to its own node toward the local force accumulator.

## Interface
- NUM_CELLS, 64, number of ring nodes.
- DATA_WIDTH, 32, width of one force component.
- PARTICLE_ID_WIDTH, 7, particle index width.
- NODE_ID_WIDTH, $clog2(NUM_CELLS), destination node ID width.
- NODE_ID, 0, ID of this node; range 0..NUM_CELLS-1.
- FIFO_DEPTH, 8, injection FIFO entries; must be a power of 2 and at least 2.
- FORCE_DATA_WIDTH, 3*DATA_WIDTH+PARTICLE_ID_WIDTH, payload width.
- PACKET_WIDTH, FORCE_DATA_WIDTH+NODE_ID_WIDTH, packet width. Destination ID occupies bits [PACKET_WIDTH-1 -: NODE_ID_WIDTH]; the payload occupies the low bits.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- local_pkt_in  in  PACKET_WIDTH  packet from the mapping stage.
- local_valid_in  in  1  local_pkt_in is valid.
- local_ready_out  out  1  FIFO can accept a packet; equals !full.
- ring_pkt_in  in  PACKET_WIDTH  packet from the upstream node.
- ring_valid_in  in  1  ring slot occupied.
- ring_pkt_out  out  PACKET_WIDTH  registered packet to the downstream node.
- ring_valid_out  out  1  registered slot-occupied flag.
- force_out  out  FORCE_DATA_WIDTH  registered ejected payload.
- force_valid_out  out  1  force_out is valid.
- fifo_count_out  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Local write: occurs when local_valid_in && local_ready_out. There is no write-through when the FIFO is full, even if the FIFO is read in the same cycle.
- Ring eject: occurs when ring_valid_in and the dest field == NODE_ID. The payload goes to force_out. The slot becomes free for this cycle.
- Ring forward: occurs when ring_valid_in and dest != NODE_ID. The packet is registered onto ring_pkt_out unchanged. Forwarded ring traffic always has priority over injection.
- Slot free: defined as !ring_valid_in, or a ring eject this cycle.
- FIFO head, destination != NODE_ID: the head is popped onto ring_pkt_out only when the slot is free.
- FIFO head, destination == NODE_ID (self-packet): it never enters the ring. It is popped directly to force_out, but only in a cycle with no ring eject; a ring eject wins.
- Per cycle limits:
  - At most one pop.
  - At most one force_out write.
  - At most one ring_pkt_out write.
- When ring_valid_out is 0, ring_pkt_out holds its previous value. The same holds for force_out when force_valid_out is 0.
- The ring has no backpressure. Nothing is ever dropped; a blocked injection simply stays in the FIFO.
- fifo_count_out: +1 on a write only, −1 on a pop only, unchanged when both occur in the same cycle.
- Read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.

## Timing
- Reset (asynchronous, immediate):
  - ring_valid_out=0, force_valid_out=0.
  - ring_pkt_out=0, force_out=0.
  - fifo_count_out=0, local_ready_out=1, pointers 0.
  - The FIFO is emptied and in-flight contents are discarded.
- Reset mid-operation: packets are lost. After deassertion the first accepted write behaves as from empty.
- Forwarding latency: ring_pkt_in sampled at edge E appears on ring_pkt_out after E (1 cycle per hop).
- Eject latency: a ring packet sampled at edge E produces force_valid_out=1 after E.
- Injection latency: a local packet written at edge E0 into an empty FIFO is popped at edge E0+1 if the slot is free there. ring_valid_out (or force_valid_out for a self-packet) rises after E0+1, giving a minimum of 2 cycles.
- local_ready_out is combinational from the count only; it is 0 exactly when fifo_count_out==FIFO_DEPTH.

## Test plan
- Forward: NODE_ID=5, ring_valid_in=1 with dest=9 for 1 cycle → next cycle ring_valid_out=1 with an identical packet; force_valid_out stays 0.
- Eject plus inject on a freed slot:
  - Setup: ring dest=5 payload 0xA5 while the FIFO head has dest=2.
  - Expect: next cycle force_out=0xA5 valid, ring_pkt_out=the head packet, fifo_count_out decremented.
- Ring priority / no starvation of data:
  - Setup: 3 packets with dest=2 queued; ring_valid_in=1 with dest=7 for 10 cycles.
  - Expect: fifo_count_out stays 3 and the ring forwards 10 packets. Once ring_valid_in drops, the 3 packets inject on 3 consecutive cycles in FIFO order.
- Self-packet collision:
  - Setup: FIFO head has dest=5 and a ring eject with dest=5 arrives in the same cycle.
  - Expect: the ring payload is ejected first; the self-packet is ejected the following cycle; ring_valid_out remains 0.
- Full FIFO with wrap-around:
  - Setup: ring saturated with foreign traffic; write FIFO_DEPTH=8 packets.
  - Expect: local_ready_out=0 and count=8; a 9th write with local_valid_in=1 is not accepted.
  - Then free the ring and keep writing: 20 packets exit in order across a pointer wrap with no loss or duplication.
- Reset mid-operation:
  - Setup: assert rst asynchronously with count=4 and ring_valid_out=1.
  - Expect: outputs clear immediately without waiting for a clock edge. After release, count=0, local_ready_out=1, and the first packet appears on the ring 2 cycles after its write.

Source files
------------

// File: rtl/ring_node_router.sv
// rtl/ring_node_router.sv - per-node slotted-ring router with injection FIFO and local force eject
//
// Purpose: buffers locally mapped writeback packets in an injection FIFO and
// merges them onto a unidirectional slotted ring, one register per hop. Ring
// packets addressed to this node are ejected as force payloads. Forwarded ring
// traffic always has priority over injection.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   local_pkt_in      packet from the mapping stage
//   local_valid_in    local_pkt_in is valid
//   local_ready_out   injection FIFO not full
//   ring_pkt_in       packet from the upstream node
//   ring_valid_in     upstream slot occupied
//   ring_pkt_out      registered packet to the downstream node
//   ring_valid_out    registered slot-occupied flag
//   force_out         registered ejected payload
//   force_valid_out   force_out is valid
//   fifo_count_out    current injection FIFO occupancy
module ring_node_router #(
   parameter int NUM_CELLS         = 64,
   parameter int DATA_WIDTH        = 32,
   parameter int PARTICLE_ID_WIDTH = 7,
   parameter int NODE_ID_WIDTH     = $clog2(NUM_CELLS),
   parameter int NODE_ID           = 0,
   parameter int FIFO_DEPTH        = 8,
   parameter int FORCE_DATA_WIDTH  = 3*DATA_WIDTH+PARTICLE_ID_WIDTH,
   parameter int PACKET_WIDTH      = FORCE_DATA_WIDTH+NODE_ID_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [PACKET_WIDTH-1:0]       local_pkt_in,
   input  logic                          local_valid_in,
   output logic                          local_ready_out,
   input  logic [PACKET_WIDTH-1:0]       ring_pkt_in,
   input  logic                          ring_valid_in,
   output logic [PACKET_WIDTH-1:0]       ring_pkt_out,
   output logic                          ring_valid_out,
   output logic [FORCE_DATA_WIDTH-1:0]   force_out,
   output logic                          force_valid_out,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [NODE_ID_WIDTH-1:0] MY_ID = NODE_ID_WIDTH'(NODE_ID);

   logic [PACKET_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [CNT_W-1:0]        count;

   logic [PACKET_WIDTH-1:0] head;
   logic                    fifo_empty;
   logic                    head_self;
   logic                    ring_eject;
   logic                    ring_fwd;
   logic                    slot_free;
   logic                    pop_ring;
   logic                    pop_self;
   logic                    pop;
   logic                    wr;

   assign head       = mem[rd_ptr];
   assign fifo_empty = (count == '0);
   assign head_self  = (head[PACKET_WIDTH-1 -: NODE_ID_WIDTH] == MY_ID);

   assign ring_eject = ring_valid_in && (ring_pkt_in[PACKET_WIDTH-1 -: NODE_ID_WIDTH] == MY_ID);
   assign ring_fwd   = ring_valid_in && !ring_eject;
   // An ejected ring packet vacates its slot, so the outgoing slot is reusable.
   assign slot_free  = !ring_valid_in || ring_eject;

   // Foreign-bound head needs a free slot; a self-bound head needs the force
   // port, which a ring eject claims first.
   assign pop_ring = !fifo_empty && !head_self && slot_free;
   assign pop_self = !fifo_empty && head_self && !ring_eject;
   assign pop      = pop_ring || pop_self;

   assign local_ready_out = (count != CNT_W'(FIFO_DEPTH));
   assign wr              = local_valid_in && local_ready_out;
   assign fifo_count_out  = count;

   // Storage has no reset; emptiness is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (wr) begin
         mem[wr_ptr] <= local_pkt_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ring_valid_out  <= 1'b0;
         ring_pkt_out    <= '0;
         force_valid_out <= 1'b0;
         force_out       <= '0;
      end else begin
         ring_valid_out  <= ring_fwd || pop_ring;
         force_valid_out <= ring_eject || pop_self;
         if (ring_fwd) begin
            ring_pkt_out <= ring_pkt_in;
         end else if (pop_ring) begin
            ring_pkt_out <= head;
         end
         if (ring_eject) begin
            force_out <= ring_pkt_in[FORCE_DATA_WIDTH-1:0];
         end else if (pop_self) begin
            force_out <= head[FORCE_DATA_WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_ring_node_router.sv
// tb/tb_ring_node_router.sv - directed table-driven bench for ring_node_router (NODE_ID=5)
module tb_ring_node_router;

   localparam int NIW = 6;
   localparam int FW  = 103;
   localparam int PW  = FW + NIW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [PW-1:0] local_pkt_in = '0;
   logic          local_valid_in = 1'b0;
   logic          local_ready_out;
   logic [PW-1:0] ring_pkt_in = '0;
   logic          ring_valid_in = 1'b0;
   logic [PW-1:0] ring_pkt_out;
   logic          ring_valid_out;
   logic [FW-1:0] force_out;
   logic          force_valid_out;
   logic [3:0]    fifo_count_out;

   int n_tests = 0;
   int n_fail  = 0;

   ring_node_router #(
      .NUM_CELLS(64), .DATA_WIDTH(32), .PARTICLE_ID_WIDTH(7),
      .NODE_ID(5), .FIFO_DEPTH(8)
   ) dut (
      .clk(clk), .rst(rst),
      .local_pkt_in(local_pkt_in), .local_valid_in(local_valid_in),
      .local_ready_out(local_ready_out),
      .ring_pkt_in(ring_pkt_in), .ring_valid_in(ring_valid_in),
      .ring_pkt_out(ring_pkt_out), .ring_valid_out(ring_valid_out),
      .force_out(force_out), .force_valid_out(force_valid_out),
      .fifo_count_out(fifo_count_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        lv;  logic [5:0] ld; logic [31:0] lp;
      logic        rv;  logic [5:0] rd; logic [31:0] rp;
      logic        erv; logic [5:0] ed; logic [31:0] ep;
      logic        efv; logic [31:0] ef;
      int          ecnt;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [PW-1:0] mk(input logic [5:0] d, input logic [31:0] p);
      return {d, {(FW-32){1'b0}}, p};
   endfunction

   function automatic logic [FW-1:0] fp(input logic [31:0] p);
      return {{(FW-32){1'b0}}, p};
   endfunction

   task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic lv, input logic [5:0] ld, input logic [31:0] lp,
                        input logic rv, input logic [5:0] rd, input logic [31:0] rp);
      local_valid_in = lv;
      local_pkt_in   = mk(ld, lp);
      ring_valid_in  = rv;
      ring_pkt_in    = mk(rd, rp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [PW-1:0] sb[$];
      logic [PW-1:0] exp_pkt;
      int mcount;
      int sent;
      int recvd;
      int cyc;
      logic acc;
      logic pop;

      //               lv ld  lp     rv rd  rp      erv ed  ep     efv ef    cnt
      tbl.push_back('{1'b0, 6'd0, 32'h0,  1'b1, 6'd9, 32'h11, 1'b1, 6'd9, 32'h11, 1'b0, 32'h0,  0});
      tbl.push_back('{1'b0, 6'd0, 32'h0,  1'b0, 6'd0, 32'h0,  1'b0, 6'd9, 32'h11, 1'b0, 32'h0,  0});
      tbl.push_back('{1'b0, 6'd0, 32'h0,  1'b1, 6'd5, 32'h22, 1'b0, 6'd9, 32'h11, 1'b1, 32'h22, 0});
      tbl.push_back('{1'b1, 6'd2, 32'h33, 1'b1, 6'd7, 32'h44, 1'b1, 6'd7, 32'h44, 1'b0, 32'h22, 1});
      tbl.push_back('{1'b0, 6'd0, 32'h0,  1'b1, 6'd5, 32'hA5, 1'b1, 6'd2, 32'h33, 1'b1, 32'hA5, 0});
      tbl.push_back('{1'b1, 6'd3, 32'h55, 1'b0, 6'd0, 32'h0,  1'b0, 6'd2, 32'h33, 1'b0, 32'hA5, 1});
      tbl.push_back('{1'b0, 6'd0, 32'h0,  1'b0, 6'd0, 32'h0,  1'b1, 6'd3, 32'h55, 1'b0, 32'hA5, 0});
      tbl.push_back('{1'b1, 6'd5, 32'h66, 1'b1, 6'd9, 32'h77, 1'b1, 6'd9, 32'h77, 1'b0, 32'hA5, 1});
      tbl.push_back('{1'b0, 6'd0, 32'h0,  1'b1, 6'd5, 32'h88, 1'b0, 6'd9, 32'h77, 1'b1, 32'h88, 1});
      tbl.push_back('{1'b0, 6'd0, 32'h0,  1'b0, 6'd0, 32'h0,  1'b0, 6'd9, 32'h77, 1'b1, 32'h66, 0});
      tbl.push_back('{1'b1, 6'd4, 32'hAA, 1'b0, 6'd0, 32'h0,  1'b0, 6'd9, 32'h77, 1'b0, 32'h66, 1});
      tbl.push_back('{1'b1, 6'd4, 32'hBB, 1'b0, 6'd0, 32'h0,  1'b1, 6'd4, 32'hAA, 1'b0, 32'h66, 1});
      tbl.push_back('{1'b0, 6'd0, 32'h0,  1'b0, 6'd0, 32'h0,  1'b1, 6'd4, 32'hBB, 1'b0, 32'h66, 0});
      tbl.push_back('{1'b0, 6'd0, 32'h0,  1'b0, 6'd0, 32'h0,  1'b0, 6'd4, 32'hBB, 1'b0, 32'h66, 0});

      // Reset state
      #2;
      check("reset ring_valid_out", ring_valid_out, 0);
      check("reset force_valid_out", force_valid_out, 0);
      check("reset ring_pkt_out", ring_pkt_out, 0);
      check("reset force_out", force_out, 0);
      check("reset count", fifo_count_out, 0);
      check("reset ready", local_ready_out, 1);
      #10 rst = 1'b0;

      // Table-driven cycles
      foreach (tbl[i]) begin
         drive(tbl[i].lv, tbl[i].ld, tbl[i].lp, tbl[i].rv, tbl[i].rd, tbl[i].rp);
         step();
         check($sformatf("row%0d ring_valid_out", i), ring_valid_out, tbl[i].erv);
         check($sformatf("row%0d ring_pkt_out", i), ring_pkt_out, mk(tbl[i].ed, tbl[i].ep));
         check($sformatf("row%0d force_valid_out", i), force_valid_out, tbl[i].efv);
         check($sformatf("row%0d force_out", i), force_out, fp(tbl[i].ef));
         check($sformatf("row%0d count", i), fifo_count_out, tbl[i].ecnt);
      end

      // Ring priority: 3 queued packets wait behind 10 cycles of foreign traffic
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 6'd2, 32'h101 + k, 1'b1, 6'd7, 32'h300 + k);
         step();
         check($sformatf("prio fill%0d count", k), fifo_count_out, k + 1);
      end
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 6'd0, 32'h0, 1'b1, 6'd7, 32'h400 + k);
         step();
         check($sformatf("prio fwd%0d valid", k), ring_valid_out, 1);
         check($sformatf("prio fwd%0d pkt", k), ring_pkt_out, mk(6'd7, 32'h400 + k));
         check($sformatf("prio fwd%0d count", k), fifo_count_out, 3);
      end
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0);
         step();
         check($sformatf("prio inj%0d valid", k), ring_valid_out, 1);
         check($sformatf("prio inj%0d pkt", k), ring_pkt_out, mk(6'd2, 32'h101 + k));
      end
      check("prio drained count", fifo_count_out, 0);

      // Full FIFO with wrap-around
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 6'd2, 32'h200 + k, 1'b1, 6'd7, 32'h500 + k);
         step();
         sb.push_back(mk(6'd2, 32'h200 + k));
      end
      check("full count", fifo_count_out, 8);
      check("full ready", local_ready_out, 0);
      drive(1'b1, 6'd2, 32'h2FF, 1'b1, 6'd7, 32'h5FF);
      step();
      check("full 9th rejected count", fifo_count_out, 8);
      mcount = 8;
      sent   = 8;
      recvd  = 0;
      cyc    = 0;
      while (!(sent == 20 && mcount == 0) && cyc < 100) begin
         drive(sent < 20, 6'd2, 32'h200 + sent, 1'b0, 6'd0, 32'h0);
         check($sformatf("wrap c%0d ready", cyc), local_ready_out, mcount < 8);
         acc = (sent < 20) && (mcount < 8);
         pop = (mcount > 0);
         step();
         check($sformatf("wrap c%0d valid", cyc), ring_valid_out, pop);
         if (pop) begin
            exp_pkt = sb.pop_front();
            check($sformatf("wrap c%0d pkt", cyc), ring_pkt_out, exp_pkt);
            recvd++;
         end
         if (acc) begin
            sb.push_back(mk(6'd2, 32'h200 + sent));
            sent++;
         end
         mcount = mcount + (acc ? 1 : 0) - (pop ? 1 : 0);
         check($sformatf("wrap c%0d count", cyc), fifo_count_out, mcount);
         cyc++;
      end
      check("wrap packets received", recvd, 20);
      check("wrap packets sent", sent, 20);

      // Reset mid-operation
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 6'd2, 32'h600 + k, 1'b1, 6'd7, 32'h700 + k);
         step();
      end
      drive(1'b0, 6'd0, 32'h0, 1'b1, 6'd7, 32'h7FF);
      check("pre-reset count", fifo_count_out, 4);
      check("pre-reset ring_valid_out", ring_valid_out, 1);
      #2 rst = 1'b1;
      #1;
      check("async reset ring_valid_out", ring_valid_out, 0);
      check("async reset ring_pkt_out", ring_pkt_out, 0);
      check("async reset force_out", force_out, 0);
      check("async reset count", fifo_count_out, 0);
      check("async reset ready", local_ready_out, 1);
      #2 rst = 1'b0;
      drive(1'b1, 6'd3, 32'h800, 1'b0, 6'd0, 32'h0);
      step();
      check("post-reset write count", fifo_count_out, 1);
      check("post-reset write ring_valid_out", ring_valid_out, 0);
      drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0);
      step();
      check("post-reset inject valid", ring_valid_out, 1);
      check("post-reset inject pkt", ring_pkt_out, mk(6'd3, 32'h800));
      check("post-reset inject count", fifo_count_out, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
